// File: rtl/memory_responder_pkg.sv
// Shared types for the memory responder: FSM states, op codes, default widths.
package memory_responder_pkg;

  localparam int DATA_W_D     = 32;
  localparam int ADDR_W_D     = 26;
  localparam int DEPTH_LOG2_D = 10;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_ILL = 2'd2
  } op_t;

endpackage

// File: rtl/memory_responder_if.sv
// CPU-side memory bus: request strobes, address, data and completion flags.
interface memory_responder_if
  import memory_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
);

  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ready;
  logic              err;

  modport master (
    output addr, read, write, data_in,
    input  data_out, ready, err
  );

  modport slave (
    input  addr, read, write, data_in,
    output data_out, ready, err
  );

endinterface

// File: rtl/memory_responder_sram.sv
// 1R1W word array: synchronous write, read port sampled by the parent.
module memory_responder_sram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// Memory bus responder: wait-state FSM, request latches and window decode
// in front of a small SRAM.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_D,
  parameter int                ADDR_W      = ADDR_W_D,
  parameter int                DEPTH_LOG2  = DEPTH_LOG2_D,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 26'h1000000,
  parameter int                WAIT_STATES = 2
) (
  input logic               clk,
  input logic               rst,
  memory_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  state_t            state, state_nx;
  op_t               op_q, op_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              load;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rdata;
  logic              ready_q, err_q;
  logic              strobe;
  logic              in_win;
  logic              acc;
  logic              we;

  assign strobe = (op_q == OP_RD) ? bus.read : bus.write;
  assign in_win = addr_q[ADDR_W-1:DEPTH_LOG2]
               == BASE_ADDR[ADDR_W-1:DEPTH_LOG2];
  assign acc    = (state == S_ACC);
  // gating with rst keeps a reset in the ACC cycle from committing
  assign we     = acc & (op_q == OP_WR) & in_win & rst;

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    cnt_nx   = cnt;
    load     = 1'b0;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          bus.read & bus.write: begin
            op_nx    = OP_ILL;
            load     = 1'b1;
            state_nx = S_ACC;
          end
          bus.read ^ bus.write: begin
            op_nx    = bus.read ? OP_RD : OP_WR;
            load     = 1'b1;
            cnt_nx   = WAIT_CNT;
            state_nx = (WAIT_CNT == '0) ? S_ACC : S_WAIT;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (!strobe)
          state_nx = S_IDLE;
        else if (cnt == CNT_W'(1))
          state_nx = S_ACC;
      end
      S_ACC:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      op_q   <= OP_RD;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      op_q  <= op_nx;
      cnt   <= cnt_nx;
      if (load) begin
        addr_q <= bus.addr;
        data_q <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      ready_q <= acc;
      err_q   <= acc & ((op_q == OP_ILL) | !in_win);
      if (acc & (op_q == OP_RD))
        dout_q <= in_win ? rdata : '0;
    end
  end

  memory_responder_sram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk   (clk),
    .we    (we),
    .waddr (addr_q[DEPTH_LOG2-1:0]),
    .wdata (data_q),
    .raddr (addr_q[DEPTH_LOG2-1:0]),
    .rdata (rdata)
  );

  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.data_out = dout_q;

endmodule
